// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register countdown scoreboard plus the mul/div busy
// counter. Drives the F/D stall and reports which registers still have writers in flight.
module hazard_scoreboard #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned RW      = 5,
    parameter int unsigned TW      = 2,
    parameter int unsigned CW      = 4,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            d_valid_i,
    input  logic [RW-1:0]   d_rs_i,
    input  logic            d_rs_rd_i,
    input  logic [TW-1:0]   d_rs_use_i,
    input  logic [RW-1:0]   d_rt_i,
    input  logic            d_rt_rd_i,
    input  logic [TW-1:0]   d_rt_use_i,
    input  logic            d_wr_i,
    input  logic [RW-1:0]   d_wa_i,
    input  logic [TW-1:0]   d_wr_lat_i,
    input  logic            d_md_start_i,
    input  logic            d_md_div_i,
    input  logic            d_md_use_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            stall_rs_o,
    output logic            stall_rt_o,
    output logic            stall_md_o,
    output logic            md_busy_o,
    output logic [NREG-1:0] pending_o
);

    logic [TW-1:0] timer_q [NREG];
    logic [TW-1:0] timer_d [NREG];
    logic [CW-1:0] md_cnt_q, md_cnt_d;

    logic [TW-1:0] rs_timer, rt_timer;
    logic          rs_late, rt_late;
    logic          issue;

    // A timer of t means the writer's result becomes forwardable t-1 cycles after an
    // instruction issuing now; the consumer stalls only if that is later than its use slot.
    always_comb begin
        rs_timer = timer_q[d_rs_i];
        rt_timer = timer_q[d_rt_i];
        rs_late  = (rs_timer != '0) && ((rs_timer - TW'(1)) > d_rs_use_i);
        rt_late  = (rt_timer != '0) && ((rt_timer - TW'(1)) > d_rt_use_i);
    end

    always_comb begin
        stall_rs_o = d_valid_i & d_rs_rd_i & (d_rs_i != '0) & rs_late;
        stall_rt_o = d_valid_i & d_rt_rd_i & (d_rt_i != '0) & rt_late;
        md_busy_o  = (md_cnt_q != '0);
        stall_md_o = d_valid_i & (d_md_start_i | d_md_use_i) & md_busy_o;
        stall_o    = stall_rs_o | stall_rt_o | stall_md_o;
        issue      = d_valid_i & ~stall_o & ~flush_i;
    end

    always_comb begin
        pending_o = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            pending_o[i] = |timer_q[i];
        end
    end

    // The issuing instruction's own destination overrides the decrement, so a
    // read-modify-write of one register is checked against the older writer only.
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            timer_d[i] = '0;
            if (i != 0 && !flush_i) begin
                if (issue && d_wr_i && (d_wa_i == RW'(i))) begin
                    timer_d[i] = d_wr_lat_i;
                end else if (timer_q[i] != '0) begin
                    timer_d[i] = timer_q[i] - TW'(1);
                end
            end
        end
    end

    always_comb begin
        md_cnt_d = '0;
        if (!flush_i) begin
            if (issue && d_md_start_i) begin
                md_cnt_d = d_md_div_i ? CW'(DIV_LAT) : CW'(MUL_LAT);
            end else if (md_cnt_q != '0) begin
                md_cnt_d = md_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                timer_q[i] <= '0;
            end
            md_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                timer_q[i] <= timer_d[i];
            end
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an absolute-time readiness model.
module tb_hazard_scoreboard;

    localparam int NREG    = 32;
    localparam int RW      = 5;
    localparam int TW      = 2;
    localparam int CW      = 4;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            d_valid, d_rs_rd, d_rt_rd, d_wr;
    logic [RW-1:0]   d_rs, d_rt, d_wa;
    logic [TW-1:0]   d_rs_use, d_rt_use, d_wr_lat;
    logic            d_md_start, d_md_div, d_md_use, flush;
    logic            stall, stall_rs, stall_rt, stall_md, md_busy;
    logic [NREG-1:0] pending;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(
        .NREG(NREG), .RW(RW), .TW(TW), .CW(CW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk_i(clk), .reset_i(reset), .d_valid_i(d_valid),
        .d_rs_i(d_rs), .d_rs_rd_i(d_rs_rd), .d_rs_use_i(d_rs_use),
        .d_rt_i(d_rt), .d_rt_rd_i(d_rt_rd), .d_rt_use_i(d_rt_use),
        .d_wr_i(d_wr), .d_wa_i(d_wa), .d_wr_lat_i(d_wr_lat),
        .d_md_start_i(d_md_start), .d_md_div_i(d_md_div), .d_md_use_i(d_md_use),
        .flush_i(flush), .stall_o(stall), .stall_rs_o(stall_rs), .stall_rt_o(stall_rt),
        .stall_md_o(stall_md), .md_busy_o(md_busy), .pending_o(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic clr();
        d_valid = 0; d_rs = 0; d_rs_rd = 0; d_rs_use = 0;
        d_rt = 0; d_rt_rd = 0; d_rt_use = 0;
        d_wr = 0; d_wa = 0; d_wr_lat = 0;
        d_md_start = 0; d_md_div = 0; d_md_use = 0; flush = 0;
    endtask

    task automatic step(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic writer(input int wa, input int lat);
        clr(); d_valid = 1; d_wr = 1; d_wa = RW'(wa); d_wr_lat = TW'(lat);
    endtask

    // Model: each register remembers the absolute cycle its result becomes forwardable;
    // the mul/div unit remembers its last busy cycle.
    initial begin
        int n;
        bit ok;
        int rdy [NREG];
        int md_end;
        logic e_rs, e_rt, e_md, e_st;
        logic [NREG-1:0] e_pend;
        n = 100; ok = 0; md_end = 0;
        foreach (rdy[i]) rdy[i] = 0;
        forever begin
            @(negedge clk);
            n++;
            e_st = 0;
            if (ok) begin
                e_rs = d_valid && d_rs_rd && d_rs != 0 && rdy[d_rs] > n + int'(d_rs_use);
                e_rt = d_valid && d_rt_rd && d_rt != 0 && rdy[d_rt] > n + int'(d_rt_use);
                e_md = d_valid && (d_md_start || d_md_use) && md_end >= n;
                e_st = e_rs || e_rt || e_md;
                e_pend = '0;
                for (int i = 1; i < NREG; i++) e_pend[i] = (rdy[i] >= n);
                chk("m_stall", 64'(stall), 64'(e_st));
                chk("m_stall_rs", 64'(stall_rs), 64'(e_rs));
                chk("m_stall_rt", 64'(stall_rt), 64'(e_rt));
                chk("m_stall_md", 64'(stall_md), 64'(e_md));
                chk("m_md_busy", 64'(md_busy), 64'(md_end >= n));
                chk("m_pending", 64'(pending), 64'(e_pend));
            end
            if (reset || (ok && flush)) begin
                foreach (rdy[i]) rdy[i] = 0;
                md_end = 0;
                if (reset) ok = 1;
            end else if (ok && d_valid && !e_st) begin
                if (d_wr && d_wa != 0) rdy[d_wa] = n + int'(d_wr_lat);
                if (d_md_start) md_end = n + (d_md_div ? DIV_LAT : MUL_LAT);
            end
        end
    end

    initial begin
        clr(); reset = 1;
        step(2);
        reset = 0;
        #1;
        chk("reset_stall", 64'(stall), 0);
        chk("reset_busy", 64'(md_busy), 0);
        chk("reset_pending", 64'(pending), 0);

        // ALU writer r8, then branch on r8 with use 0
        writer(8, 2); #1 chk("t1_wr_nostall", 64'(stall), 0);
        step(); clr(); d_valid = 1; d_rs = 8; d_rs_rd = 1; d_rs_use = 0;
        #1 chk("t1_stall", 64'(stall), 1); chk("t1_stall_rs", 64'(stall_rs), 1);
        chk("t1_pend_a", 64'(pending[8]), 1);
        step(); #1 chk("t1_go", 64'(stall), 0); chk("t1_pend_b", 64'(pending[8]), 1);
        step(); clr(); #1 chk("t1_pend_c", 64'(pending[8]), 0);

        // Load r9 then use-1, use-0 and store-data consumers
        for (int u = 1; u >= 0; u--) begin
            writer(9, 3); step(); clr(); d_valid = 1;
            if (u == 1) begin d_rt = 9; d_rt_rd = 1; d_rt_use = 1; end
            else begin d_rs = 9; d_rs_rd = 1; d_rs_use = 0; end
            for (int k = 0; k < 2 - u; k++) begin
                #1 chk("t2_stall", 64'(stall), 1); step();
            end
            #1 chk("t2_go", 64'(stall), 0);
            step(); clr(); step(3);
        end
        writer(9, 3); step(); clr(); d_valid = 1; d_rt = 9; d_rt_rd = 1; d_rt_use = 2;
        #1 chk("t2_sw", 64'(stall), 0);
        step(); clr(); step(3);

        // Writes to r0 are ignored
        writer(0, 3); step(); clr(); d_valid = 1; d_rs = 0; d_rs_rd = 1;
        #1 chk("t3_stall", 64'(stall), 0); chk("t3_pend", 64'(pending), 0);
        step(); clr(); #1 chk("t3_pend2", 64'(pending), 0);

        // mult then mflo, div then mflo
        for (int dv = 0; dv < 2; dv++) begin
            clr(); d_valid = 1; d_md_start = 1; d_md_div = dv[0];
            step(); clr(); d_valid = 1; d_md_use = 1;
            for (int k = 0; k < (dv != 0 ? DIV_LAT : MUL_LAT); k++) begin
                #1 chk("t4_md", 64'({stall_md, md_busy, stall}), 64'h7); step();
            end
            #1 chk("t4_go", 64'(stall), 0); chk("t4_idle", 64'(md_busy), 0);
            step(); clr();
        end
        clr(); d_valid = 1; d_md_start = 1; step();
        writer(3, 2); #1 chk("t4_add", 64'(stall), 0); chk("t4_add_busy", 64'(md_busy), 1);
        step(); clr(); step(6);

        // Flush kills in-flight writer and the simultaneous issue
        writer(10, 3); d_md_start = 1; step();
        writer(11, 2); flush = 1; step();
        clr(); d_valid = 1; d_rs = 10; d_rs_rd = 1; d_rs_use = 0;
        #1 chk("t5_pend", 64'(pending), 0); chk("t5_busy", 64'(md_busy), 0);
        chk("t5_stall", 64'(stall), 0);
        step(); clr(); step();

        // Reset mid-countdown
        clr(); d_valid = 1; d_md_start = 1; step();
        writer(9, 3); step(); clr(); step();
        #1 chk("t6_busy_pre", 64'(md_busy), 1); chk("t6_pend_pre", 64'(pending[9]), 1);
        reset = 1; step(); reset = 0;
        d_valid = 1; d_md_use = 1; d_rs = 9; d_rs_rd = 1;
        #1 chk("t6_pend", 64'(pending), 0); chk("t6_busy", 64'(md_busy), 0);
        chk("t6_stall", 64'({stall, stall_rs, stall_rt, stall_md}), 0);
        step(); clr(); step();

        // Randomized traffic over a small register window
        for (int c = 0; c < 3000; c++) begin
            d_valid    = ($urandom_range(0, 3) != 0);
            d_rs       = RW'($urandom_range(0, 7));
            d_rs_rd    = 1'($urandom);
            d_rs_use   = TW'($urandom);
            d_rt       = RW'($urandom_range(0, 7));
            d_rt_rd    = 1'($urandom);
            d_rt_use   = TW'($urandom);
            d_wr       = 1'($urandom);
            d_wa       = RW'($urandom_range(0, 7));
            d_wr_lat   = TW'($urandom);
            d_md_start = ($urandom_range(0, 9) == 0);
            d_md_div   = 1'($urandom);
            d_md_use   = ($urandom_range(0, 5) == 0);
            flush      = ($urandom_range(0, 31) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 0; clr(); step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
